// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg
// Shared memory-map constants for the data-memory port, the index to byte
// address mapping, and the state encoding of the dmem_verifier FSM.
//   ROM   word indices  0..15
//   RAM   word indices 16..47 (result region)
//   VER   word indices 48..63 (expected-value region)
package dmem_map_pkg;

    localparam int ROM_LO = 0;
    localparam int ROM_HI = 15;
    localparam int RAM_LO = 16;
    localparam int RAM_HI = 47;
    localparam int VER_LO = 48;
    localparam int VER_HI = 63;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 32;
    localparam int WIDX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RD_RES = 3'd2,
        ST_RD_EXP = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // The port is byte addressed with 16-bit words: word index i sits on a[8:1].
    function automatic logic [ADDR_W-1:0] widx_to_byte(input logic [WIDX_W-1:0] widx);
        return {{(ADDR_W-WIDX_W-1){1'b0}}, widx, 1'b0};
    endfunction

endpackage

// File: rtl/dmem_cmp_abs.sv
// dmem_cmp_abs
// Combinational tolerance compare of two 16-bit two's complement words.
//   res_i   : result word
//   exp_i   : expected word
//   diff_o  : signed 17-bit res - exp
//   abs_o   : |diff|, 17-bit unsigned (max 65535, never wraps)
//   match_o : 1 when abs_o <= TOL
module dmem_cmp_abs
    import dmem_map_pkg::*;
#(
    parameter int TOL = 0
) (
    input  logic [DATA_W-1:0] res_i,
    input  logic [DATA_W-1:0] exp_i,
    output logic [DATA_W:0]   diff_o,
    output logic [DATA_W:0]   abs_o,
    output logic              match_o
);

    localparam logic [DATA_W:0] TOL_W = (DATA_W+1)'(TOL);

    // One extra bit keeps the full range: -65535..+65535 fits in 17 bits signed.
    assign diff_o  = {res_i[DATA_W-1], res_i} - {exp_i[DATA_W-1], exp_i};
    assign abs_o   = diff_o[DATA_W] ? (~diff_o + 1'b1) : diff_o;
    assign match_o = (abs_o <= TOL_W);

endmodule

// File: rtl/dmem_verifier.sv
// dmem_verifier
// Read-only bus master that walks N result words and N expected words and
// counts the pairs whose absolute difference exceeds TOL.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a check (only sampled in IDLE)
//   busy, done          : state != IDLE, one-cycle completion pulse
//   pass, err_cnt,
//   first_err           : results, held until the next accepted start
//   mem_req / mem_gnt   : port request / arbiter grant
//   mem_a, mem_we,
//   mem_wd, mem_rd      : data-memory port (never writes)
//   dbg_state           : current FSM state, for observation
//
// Handshake: mem_req stays high for the whole walk (REQ, RD_RES, RD_EXP). A
// word moves only in a cycle where the FSM is in RD_RES or RD_EXP and mem_gnt
// is high at the closing edge; mem_rd is sampled at that same edge. Losing the
// grant sends the FSM back to REQ and the current pair is read again.
module dmem_verifier
    import dmem_map_pkg::*;
#(
    parameter int N        = 16,
    parameter int RES_BASE = 32,
    parameter int EXP_BASE = 48,
    parameter int TOL      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_cnt,
    output logic [3:0]        first_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic [2:0]        dbg_state
);

    localparam logic [3:0]        LAST_IDX = 4'(N - 1);
    localparam logic [WIDX_W-1:0] RES_W    = WIDX_W'(RES_BASE);
    localparam logic [WIDX_W-1:0] EXP_W    = WIDX_W'(EXP_BASE);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [4:0]         err_cnt_q, err_cnt_d;
    logic [3:0]         first_err_q, first_err_d;
    logic               pass_q, pass_d;

    logic [DATA_W:0]    cmp_diff;
    logic [DATA_W:0]    cmp_abs;
    logic               cmp_match;

    dmem_cmp_abs #(
        .TOL (TOL)
    ) u_cmp (
        .res_i   (res_q),
        .exp_i   (mem_rd[DATA_W-1:0]),
        .diff_o  (cmp_diff),
        .abs_o   (cmp_abs),
        .match_o (cmp_match)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        res_d       = res_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    idx_d       = 4'd0;
                    err_cnt_d   = 5'd0;
                    first_err_d = 4'd0;
                    pass_d      = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_RD_RES;
            end
            ST_RD_RES: begin
                if (mem_gnt) begin
                    res_d   = mem_rd[DATA_W-1:0];
                    state_d = ST_RD_EXP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RD_EXP: begin
                if (!mem_gnt) begin
                    // Counters untouched: the pair is replayed from RD_RES.
                    state_d = ST_REQ;
                end else begin
                    if (!cmp_match) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                        if (err_cnt_q == 5'd0) first_err_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        // Registered here so pass is already valid in the DONE cycle.
                        pass_d  = (err_cnt_d == 5'd0);
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_RD_RES;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            res_q       <= '0;
            err_cnt_q   <= 5'd0;
            first_err_q <= 4'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        mem_a = '0;
        case (state_q)
            ST_RD_RES: mem_a = widx_to_byte(RES_W + {4'd0, idx_q});
            ST_RD_EXP: mem_a = widx_to_byte(EXP_W + {4'd0, idx_q});
            default:   mem_a = '0;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_req   = (state_q == ST_REQ) || (state_q == ST_RD_RES) || (state_q == ST_RD_EXP);
    assign mem_we    = 1'b0;
    assign mem_wd    = 32'd0;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_verifier.sv
// Directed bench for dmem_verifier. Three instances with TOL = 0, 2 and 255
// share one memory image, clock, reset, start and grant, so one walk checks
// all three tolerances at once.
module tb_dmem_verifier;
    import dmem_map_pkg::*;

    logic clk;
    logic rst_n;
    logic start;
    logic gnt;

    logic [31:0] mem [0:63];

    logic        a_busy, a_done, a_pass, a_req, a_we;
    logic [4:0]  a_err;
    logic [3:0]  a_first;
    logic [31:0] a_addr, a_wd, a_rd;
    logic [2:0]  a_dbg;

    logic        b_busy, b_done, b_pass, b_req, b_we;
    logic [4:0]  b_err;
    logic [3:0]  b_first;
    logic [31:0] b_addr, b_wd, b_rd;
    logic [2:0]  b_dbg;

    logic        c_busy, c_done, c_pass, c_req, c_we;
    logic [4:0]  c_err;
    logic [3:0]  c_first;
    logic [31:0] c_addr, c_wd, c_rd;
    logic [2:0]  c_dbg;

    assign a_rd = mem[a_addr[6:1]];
    assign b_rd = mem[b_addr[6:1]];
    assign c_rd = mem[c_addr[6:1]];

    dmem_verifier #(.N(16), .RES_BASE(32), .EXP_BASE(48), .TOL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_cnt(a_err), .first_err(a_first), .mem_req(a_req),
        .mem_gnt(gnt), .mem_a(a_addr), .mem_we(a_we), .mem_wd(a_wd),
        .mem_rd(a_rd), .dbg_state(a_dbg)
    );

    dmem_verifier #(.N(16), .RES_BASE(32), .EXP_BASE(48), .TOL(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_cnt(b_err), .first_err(b_first), .mem_req(b_req),
        .mem_gnt(gnt), .mem_a(b_addr), .mem_we(b_we), .mem_wd(b_wd),
        .mem_rd(b_rd), .dbg_state(b_dbg)
    );

    dmem_verifier #(.N(16), .RES_BASE(32), .EXP_BASE(48), .TOL(255)) u255 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(c_busy), .done(c_done),
        .pass(c_pass), .err_cnt(c_err), .first_err(c_first), .mem_req(c_req),
        .mem_gnt(gnt), .mem_a(c_addr), .mem_we(c_we), .mem_wd(c_wd),
        .mem_rd(c_rd), .dbg_state(c_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // monitors sampled on the inactive edge
    logic        we_seen = 1'b0;
    logic        log_en  = 1'b0;
    logic        done_watch = 1'b0;
    logic        done_seen  = 1'b0;
    logic [31:0] addr_log[$];

    always @(negedge clk) begin
        if (a_we || b_we || c_we || (a_wd != 32'd0) || (b_wd != 32'd0) || (c_wd != 32'd0))
            we_seen = 1'b1;
        if (log_en && a_addr != 32'd0)
            addr_log.push_back(a_addr);
        if (done_watch && (a_done || b_done || c_done))
            done_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic fill_equal();
        logic [15:0] v;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            v = 16'h1000 + 16'(i * 273);
            // upper halves differ on purpose: they must be ignored
            mem[32+i] = {16'hDEAD, v};
            mem[48+i] = {16'hBEEF, v};
        end
    endtask

    // Caller is at #1 after a rising edge. Returns the cycle number (edge that
    // samples start is edge 0) in which done was observed, or -1 on timeout.
    task automatic run_check(input int drop_idx, input int pulse_at, output int done_cyc);
        int cyc;
        int drop_left;
        bit dropped;
        done_cyc  = -1;
        drop_left = 0;
        dropped   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 200 && done_cyc < 0) begin
            if (a_done) begin
                done_cyc = cyc;
            end else begin
                if (drop_left > 0) begin
                    drop_left--;
                    if (drop_left == 0) gnt = 1'b1;
                end
                if (!dropped && drop_idx >= 0 && a_dbg == ST_RD_EXP &&
                    a_addr == 32'((48 + drop_idx) * 2)) begin
                    gnt       = 1'b0;
                    drop_left = 3;
                    dropped   = 1'b1;
                end
                start = (cyc == pulse_at);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        gnt   = 1'b1;
    endtask

    int dc;
    int wait_cyc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        gnt   = 1'b1;
        fill_equal();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("rst_busy",      32'(a_busy),  32'd0);
        check("rst_done",      32'(a_done),  32'd0);
        check("rst_pass",      32'(a_pass),  32'd0);
        check("rst_req",       32'(a_req),   32'd0);
        check("rst_we",        32'(a_we),    32'd0);
        check("rst_err_cnt",   32'(a_err),   32'd0);
        check("rst_first_err", 32'(a_first), 32'd0);
        check("rst_mem_a",     a_addr,       32'd0);
        check("rst_mem_wd",    a_wd,         32'd0);
        check("rst_state",     32'(a_dbg),   32'(ST_IDLE));

        // all pairs identical, gnt held high
        log_en = 1'b1;
        run_check(-1, -1, dc);
        log_en = 1'b0;
        check("eq_done_cycle", 32'(dc),      32'd34);
        check("eq_pass",       32'(a_pass),  32'd1);
        check("eq_err_cnt",    32'(a_err),   32'd0);
        check("eq_first_err",  32'(a_first), 32'd0);
        check("eq_addr_count", 32'(addr_log.size()), 32'd32);
        if (addr_log.size() == 32) begin
            check("addr_first_res", addr_log[0],  32'h40);
            check("addr_first_exp", addr_log[1],  32'h60);
            check("addr_last_res",  addr_log[30], 32'h5E);
            check("addr_last_exp",  addr_log[31], 32'h7E);
        end
        @(posedge clk); #1;
        check("eq_done_pulse", 32'(a_done), 32'd0);
        check("eq_pass_held",  32'(a_pass), 32'd1);
        check("eq_busy_idle",  32'(a_busy), 32'd0);

        // offsets 3 and 9 differ by 2
        mem[32+3] = 32'h0000_0100; mem[48+3] = 32'h0000_0102;
        mem[32+9] = 32'h0000_0100; mem[48+9] = 32'h0000_0102;
        run_check(-1, -1, dc);
        check("mm_done_cycle",  32'(dc),      32'd34);
        check("mm_t0_err_cnt",  32'(a_err),   32'd2);
        check("mm_t0_first",    32'(a_first), 32'd3);
        check("mm_t0_pass",     32'(a_pass),  32'd0);
        check("mm_t2_err_cnt",  32'(b_err),   32'd0);
        check("mm_t2_first",    32'(b_first), 32'd0);
        check("mm_t2_pass",     32'(b_pass),  32'd1);
        check("mm_t255_pass",   32'(c_pass),  32'd1);
        @(posedge clk); #1;

        // add -1 vs +1 at offset 5 and the extreme pair at offset 12
        mem[32+5]  = 32'h0000_FFFF; mem[48+5]  = 32'h0000_0001;
        mem[32+12] = 32'h0000_8000; mem[48+12] = 32'h0000_7FFF;
        run_check(-1, -1, dc);
        check("ext_done_cycle", 32'(dc),      32'd34);
        check("ext_t0_err_cnt", 32'(a_err),   32'd4);
        check("ext_t0_first",   32'(a_first), 32'd3);
        check("ext_t2_err_cnt", 32'(b_err),   32'd1);
        check("ext_t2_first",   32'(b_first), 32'd12);
        check("ext_t255_err",   32'(c_err),   32'd1);
        check("ext_t255_first", 32'(c_first), 32'd12);
        check("ext_t255_pass",  32'(c_pass),  32'd0);
        @(posedge clk); #1;

        // grant low for 3 cycles starting in RD_EXP of idx 5: the lost RD_EXP
        // cycle, two REQ waits, the granted REQ cycle and the RD_RES replay
        // push done from cycle 34 to 39.
        run_check(5, -1, dc);
        check("drop_done_cycle", 32'(dc),      32'd39);
        check("drop_t0_err_cnt", 32'(a_err),   32'd4);
        check("drop_t0_first",   32'(a_first), 32'd3);
        check("drop_t2_err_cnt", 32'(b_err),   32'd1);
        check("drop_t255_first", 32'(c_first), 32'd12);
        @(posedge clk); #1;

        // start pulsed mid-walk is ignored
        run_check(-1, 10, dc);
        check("busy_start_done_cycle", 32'(dc),      32'd34);
        check("busy_start_err_cnt",    32'(a_err),   32'd4);
        check("busy_start_first",      32'(a_first), 32'd3);
        @(posedge clk); #1;

        // reset while reading the result word at idx 7
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (wait_cyc < 100 && !(a_dbg == ST_RD_RES && a_addr == 32'h4E)) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("rstmid_reached_idx7", 32'(wait_cyc < 100), 32'd1);
        check("rstmid_err_before",   32'(a_err),          32'd2);
        done_watch = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy",    32'(a_busy),  32'd0);
        check("rstmid_req",     32'(a_req),   32'd0);
        check("rstmid_mem_a",   a_addr,       32'd0);
        check("rstmid_err_cnt", 32'(a_err),   32'd0);
        check("rstmid_first",   32'(a_first), 32'd0);
        check("rstmid_pass",    32'(a_pass),  32'd0);
        check("rstmid_state",   32'(a_dbg),   32'(ST_IDLE));
        check("rstmid_t2_busy", 32'(b_busy),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rstmid_no_done", 32'(done_seen), 32'd0);
        check("rstmid_idle",    32'(a_busy),     32'd0);
        done_watch = 1'b0;

        check("we_never_high", 32'(we_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
